edge_det_filt: RTL and testbench
================================

Name: edge_det_filt

Overview:
- Multi-channel edge detector with per-channel glitch filter, per-channel edge-mode select, sticky pending flags, saturating event counters and a combined interrupt.
- Successor to the single-purpose edge detectors. Sits between slow external or asynchronous inputs (GPIO, keys, capture pins) and register/IRQ logic, in a fast oversampling clock domain.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
STAGE, 2, synchroniser depth per channel; 0 = inputs already synchronous, no sync flops
FILT_WIDTH, 4, width of the filter threshold and per-channel stability counter
CNT_WIDTH, 8, width of each per-channel saturating event counter

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
dat_i  in  CHANNELS  raw input levels
mode_i  in  2*CHANNELS  per-channel mode, ch i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
filt_thr_i  in  FILT_WIDTH  global filter threshold, shared by all channels
clr_i  in  CHANNELS  per-channel clear of pending flag and event counter
dat_o  out  CHANNELS  filtered level (registered)
re_o  out  CHANNELS  filtered rising-edge pulse, independent of mode
fe_o  out  CHANNELS  filtered falling-edge pulse, independent of mode
evt_o  out  CHANNELS  mode-qualified edge pulse
pend_o  out  CHANNELS  sticky pending flag (registered)
cnt_o  out  CHANNELS*CNT_WIDTH  per-channel event count, ch i at [CNT_WIDTH*(i+1)-1:CNT_WIDTH*i]
irq_o  out  1  OR of pend_o (registered-derived, glitch-free)

Behaviour:
- Reset:
  - All flops are sampled on the clk_i rising edge while rst_n_i=0 and go to 0: sync chain, filtered level, stability counters, pending flags, event counters.
  - During reset and the first cycle after it: dat_o=0, pend_o=0, cnt_o=0, irq_o=0. re_o/fe_o/evt_o are 0 while rst_n_i=0 (gated).
- Synchroniser: STAGE-flop chain per channel, output s[i]. With STAGE=0, s=dat_i.
- Filter (per channel), with level register lvl_q=dat_o and counter fc_q:
  - s==lvl_q: fc_q<=0.
  - s!=lvl_q and fc_q>=filt_thr_i: lvl_q<=s, fc_q<=0, update asserted.
  - s!=lvl_q otherwise: fc_q<=fc_q+1.
  - Net effect: s must differ from lvl_q for filt_thr_i+1 consecutive cycles to propagate. Shorter glitches are discarded.
  - filt_thr_i=0 gives plain edge detection with no filtering.
  - The ">=" compare makes a lowered threshold mid-count take effect immediately. fc_q never wraps.
- Edge pulses (combinational, same cycle as update; dat_o changes on the next edge):
  - re_o = update & s.
  - fe_o = update & ~s.
- Latency: filt_thr_i=0 gives re_o STAGE cycles after dat_i is sampled high, and dat_o one cycle later. Each threshold unit adds one cycle.
- evt_o[i] by mode: re_o when mode=01, fe_o when 10, re_o|fe_o when 11, 0 when 00. A mode change applies combinationally; filter state is unaffected by mode.
- pend_o:
  - Set on evt_o; cleared on clr_i.
  - Simultaneous evt_o and clr_i: flag is 1 (event never lost).
- Counter:
  - Increments on evt_o and saturates at 2^CNT_WIDTH-1 (no wrap).
  - clr_i zeroes it. Simultaneous clr_i and evt_o: count becomes 1.
- irq_o = |pend_o.
- Channels are fully independent. Reset mid-filter discards the partial count and the pending edge.

Test Plan:
1. STAGE=2, thr=0, mode ch0=01, dat_i[0] 0->1 held -> re_o[0]=evt_o[0]=1 for exactly one cycle, 2 cycles after sampling; dat_o[0]=1 next cycle; pend_o[0]=1, irq_o=1, cnt ch0=1.
2. thr=3: 3-cycle high glitch on ch1 -> no re_o, dat_o[1] stays 0. Then a 4-cycle high -> re_o[1] once, dat_o[1]=1. Dropping low for 2 cycles -> no fe_o.
3. mode ch2=11: toggle twice with thr=0 -> evt_o 2 pulses, cnt=2. mode=00 -> re_o/fe_o still pulse, evt_o=0, cnt unchanged. mode=10 -> only falling edges counted.
4. CNT_WIDTH=8: 300 qualified edges on ch3 -> cnt=255. clr_i[3] in the same cycle as an evt_o -> cnt=1, pend_o[3]=1. clr_i alone -> cnt=0, pend=0, irq_o falls if no other pend.
5. thr=7, ch0 mid-count at fc=4, drop thr to 2 -> level updates the next cycle. Assert rst_n_i=0 mid-count, then release -> dat_o=0, cnt=0, no spurious edges; the input must requalify fully.
6. All 4 channels edge in the same cycle with mixed modes -> evt_o equals the per-mode mask exactly, and only qualified counters increment.

Source files
------------

// File: rtl/edge_det_filt.sv
// rtl/edge_det_filt.sv - multi-channel filtered edge detector with pending flags, event counters and irq
module edge_det_filt #(
    parameter int CHANNELS   = 4,
    parameter int STAGE      = 2,
    parameter int FILT_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [CHANNELS-1:0]           dat_i,
    input  logic [2*CHANNELS-1:0]         mode_i,
    input  logic [FILT_WIDTH-1:0]         filt_thr_i,
    input  logic [CHANNELS-1:0]           clr_i,
    output logic [CHANNELS-1:0]           dat_o,
    output logic [CHANNELS-1:0]           re_o,
    output logic [CHANNELS-1:0]           fe_o,
    output logic [CHANNELS-1:0]           evt_o,
    output logic [CHANNELS-1:0]           pend_o,
    output logic [CHANNELS*CNT_WIDTH-1:0] cnt_o,
    output logic                          irq_o
);

    // synchronised input levels feeding the filters
    logic [CHANNELS-1:0] s;

    generate
        if (STAGE == 0) begin : g_nosync
            assign s = dat_i;
        end else begin : g_sync
            logic [CHANNELS-1:0] sync_q [STAGE];

            // shift raw inputs through the synchroniser chain
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    for (int k = 0; k < STAGE; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= dat_i;
                    for (int k = 1; k < STAGE; k++) sync_q[k] <= sync_q[k-1];
                end
            end

            assign s = sync_q[STAGE-1];
        end
    endgenerate

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic                  lvl_q;
        logic [FILT_WIDTH-1:0] fc_q;
        logic                  pend_q;
        logic [CNT_WIDTH-1:0]  cnt_q;
        logic [1:0]            mode;
        logic                  upd;

        assign mode = mode_i[2*i+1:2*i];
        // ">=" lets a threshold lowered mid-count take effect at once; gated so no pulse escapes during reset
        assign upd  = rst_n_i && (s[i] != lvl_q) && (fc_q >= filt_thr_i);

        assign re_o[i]  = upd & s[i];
        assign fe_o[i]  = upd & ~s[i];
        // mode bit 0 qualifies rising edges, bit 1 falling edges
        assign evt_o[i] = (mode[0] & re_o[i]) | (mode[1] & fe_o[i]);

        // glitch filter: accept a new level only after it persisted thr+1 cycles
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                lvl_q <= 1'b0;
                fc_q  <= '0;
            end else if (s[i] == lvl_q) begin
                fc_q <= '0;
            end else if (upd) begin
                lvl_q <= s[i];
                fc_q  <= '0;
            end else begin
                fc_q <= fc_q + FILT_WIDTH'(1);
            end
        end

        // sticky pending flag; a same-cycle event wins over clear
        always_ff @(posedge clk_i) begin
            if (!rst_n_i)      pend_q <= 1'b0;
            else if (evt_o[i]) pend_q <= 1'b1;
            else if (clr_i[i]) pend_q <= 1'b0;
        end

        // saturating event counter; clear with a same-cycle event restarts at one
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                cnt_q <= '0;
            end else if (clr_i[i]) begin
                cnt_q <= evt_o[i] ? CNT_WIDTH'(1) : '0;
            end else if (evt_o[i] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end

        assign dat_o[i]                            = lvl_q;
        assign pend_o[i]                           = pend_q;
        assign cnt_o[CNT_WIDTH*i +: CNT_WIDTH]     = cnt_q;
    end

    assign irq_o = |pend_o;

endmodule

// File: tb/tb_edge_det_filt.sv
// tb/tb_edge_det_filt.sv - randomized and directed self-checking bench for edge_det_filt
module tb_edge_det_filt;

    localparam int CH = 4;
    localparam int ST = 2;
    localparam int FW = 4;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [CH-1:0]     dat;
    logic [2*CH-1:0]   mode;
    logic [FW-1:0]     thr;
    logic [CH-1:0]     clr;
    logic [CH-1:0]     dat_o, re_o, fe_o, evt_o, pend_o;
    logic [CH*CW-1:0]  cnt_o;
    logic              irq_o;

    edge_det_filt #(.CHANNELS(CH), .STAGE(ST), .FILT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .dat_i(dat), .mode_i(mode), .filt_thr_i(thr),
        .clr_i(clr), .dat_o(dat_o), .re_o(re_o), .fe_o(fe_o), .evt_o(evt_o),
        .pend_o(pend_o), .cnt_o(cnt_o), .irq_o(irq_o)
    );

    int vectors = 0;
    int errors  = 0;

    // reference model: input history, accepted level, length of current differing run, flags, counts
    logic [CH-1:0] hist [$];
    bit            m_lvl  [CH];
    int            m_run  [CH];
    bit            m_pend [CH];
    int            m_cnt  [CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // apply one cycle of inputs, check all outputs against the model, then advance the model
    task automatic step(input bit r, input logic [CH-1:0] d, input logic [2*CH-1:0] m,
                        input int t, input logic [CH-1:0] cl);
        logic [CH-1:0]    s, e_re, e_fe, e_evt, e_lvl, e_pend;
        logic [CH*CW-1:0] e_cnt;
        int               run_now [CH];
        bit               upd;
        @(negedge clk);
        rst_n = r; dat = d; mode = m; thr = t[FW-1:0]; clr = cl;
        #1;
        vectors++;
        s = (ST == 0) ? d : hist[0];
        for (int i = 0; i < CH; i++) begin
            run_now[i] = (s[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            upd        = r && (run_now[i] > t);
            e_re[i]    = upd && s[i];
            e_fe[i]    = upd && !s[i];
            e_evt[i]   = (m[2*i] && e_re[i]) || (m[2*i+1] && e_fe[i]);
            e_lvl[i]   = m_lvl[i];
            e_pend[i]  = m_pend[i];
            e_cnt[CW*i +: CW] = m_cnt[i][CW-1:0];
        end
        chk("dat_o", 64'(dat_o), 64'(e_lvl));
        chk("re_o", 64'(re_o), 64'(e_re));
        chk("fe_o", 64'(fe_o), 64'(e_fe));
        chk("evt_o", 64'(evt_o), 64'(e_evt));
        chk("pend_o", 64'(pend_o), 64'(e_pend));
        chk("cnt_o", 64'(cnt_o), 64'(e_cnt));
        chk("irq_o", 64'(irq_o), 64'(|e_pend));
        for (int i = 0; i < CH; i++) begin
            if (!r) begin
                m_lvl[i] = 0; m_run[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
            end else begin
                if (e_re[i] || e_fe[i]) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                end else begin
                    m_run[i] = run_now[i];
                end
                if (e_evt[i])   m_pend[i] = 1;
                else if (cl[i]) m_pend[i] = 0;
                if (cl[i])         m_cnt[i] = e_evt[i] ? 1 : 0;
                else if (e_evt[i]) m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
            end
        end
        if (!r) begin
            hist.delete();
            for (int k = 0; k < ST; k++) hist.push_back('0);
        end else if (ST > 0) begin
            hist.push_back(d);
            void'(hist.pop_front());
        end
    endtask

    logic [CH-1:0]   rd;
    logic [2*CH-1:0] rm;
    int              rt;

    initial begin
        for (int k = 0; k < ST; k++) hist.push_back('0);
        for (int i = 0; i < CH; i++) begin
            m_lvl[i] = 0; m_run[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
        end
        rst_n = 1'b0; dat = '0; mode = '0; thr = '0; clr = '0;
        repeat (2) @(posedge clk);

        // reset state, then a single qualified rising edge on ch0
        step(0, 4'h0, 8'h01, 0, 4'h0);
        chk("reset_irq", 64'(irq_o), 64'd0);
        chk("reset_cnt", 64'(cnt_o), 64'd0);
        repeat (3) step(1, 4'h0, 8'h01, 0, 4'h0);
        step(1, 4'h1, 8'h01, 0, 4'h0);
        step(1, 4'h1, 8'h01, 0, 4'h0);
        chk("t1_re_early", 64'(re_o[0]), 64'd0);
        step(1, 4'h1, 8'h01, 0, 4'h0);
        chk("t1_re", 64'(re_o[0]), 64'd1);
        chk("t1_evt", 64'(evt_o[0]), 64'd1);
        step(1, 4'h1, 8'h01, 0, 4'h0);
        chk("t1_re_once", 64'(re_o[0]), 64'd0);
        chk("t1_dat", 64'(dat_o[0]), 64'd1);
        chk("t1_pend", 64'(pend_o[0]), 64'd1);
        chk("t1_irq", 64'(irq_o), 64'd1);
        chk("t1_cnt", 64'(cnt_o[7:0]), 64'd1);

        // threshold 3 on ch1: 3-cycle glitch rejected, 4-cycle pulse accepted, 2-cycle dip rejected
        repeat (3) step(1, 4'h1, 8'h05, 3, 4'h0);
        repeat (3) step(1, 4'h3, 8'h05, 3, 4'h0);
        repeat (6) step(1, 4'h1, 8'h05, 3, 4'h0);
        chk("t2_glitch", 64'(dat_o[1]), 64'd0);
        repeat (4) step(1, 4'h3, 8'h05, 3, 4'h0);
        repeat (2) step(1, 4'h1, 8'h05, 3, 4'h0);
        repeat (6) step(1, 4'h3, 8'h05, 3, 4'h0);
        chk("t2_level", 64'(dat_o[1]), 64'd1);

        // mode changes on ch2 with thr=0
        foreach (rm[k]) rm[k] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            rm = (p == 0) ? 8'h35 : (p == 1) ? 8'h05 : 8'h25;
            repeat (4) step(1, 4'h7, rm, 0, 4'h0);
            repeat (4) step(1, 4'h3, rm, 0, 4'h0);
        end

        // saturate ch3 with both-edge mode, then clear coincident with an event, then clear alone
        for (int k = 0; k < 300; k++) step(1, (k % 2 == 0) ? 4'hB : 4'h3, 8'hC5, 0, 4'h0);
        repeat (5) step(1, 4'h3, 8'hC5, 0, 4'h0);
        chk("t4_sat", 64'(cnt_o[31:24]), 64'd255);
        step(1, 4'hB, 8'hC5, 0, 4'h0);
        step(1, 4'hB, 8'hC5, 0, 4'h0);
        step(1, 4'hB, 8'hC5, 0, 4'h8);
        step(1, 4'hB, 8'hC5, 0, 4'h0);
        chk("t4_clr_evt_cnt", 64'(cnt_o[31:24]), 64'd1);
        chk("t4_clr_evt_pend", 64'(pend_o[3]), 64'd1);
        step(1, 4'hB, 8'hC5, 0, 4'hF);
        step(1, 4'hB, 8'hC5, 0, 4'h0);
        chk("t4_clr_cnt", 64'(cnt_o[31:24]), 64'd0);
        chk("t4_clr_irq", 64'(irq_o), 64'd0);

        // threshold lowered mid-count, then reset mid-count
        repeat (2) step(0, 4'h0, 8'hFF, 7, 4'h0);
        repeat (6) step(1, 4'h1, 8'hFF, 7, 4'h0);
        step(1, 4'h1, 8'hFF, 2, 4'h0);
        chk("t5_thr_drop", 64'(re_o[0]), 64'd1);
        step(1, 4'h1, 8'hFF, 2, 4'h0);
        chk("t5_level", 64'(dat_o[0]), 64'd1);
        repeat (4) step(1, 4'h0, 8'hFF, 7, 4'h0);
        step(0, 4'h1, 8'hFF, 7, 4'h0);
        step(1, 4'h1, 8'hFF, 3, 4'h0);
        chk("t5_rst_dat", 64'(dat_o), 64'd0);
        chk("t5_rst_cnt", 64'(cnt_o), 64'd0);
        repeat (8) step(1, 4'h1, 8'hFF, 3, 4'h0);

        // all channels edge together under mixed modes (ch3..ch0 = both, fall, rise, off)
        repeat (2) step(0, 4'h0, 8'hE4, 0, 4'h0);
        repeat (3) step(1, 4'h0, 8'hE4, 0, 4'h0);
        step(1, 4'hF, 8'hE4, 0, 4'h0);
        step(1, 4'hF, 8'hE4, 0, 4'h0);
        step(1, 4'hF, 8'hE4, 0, 4'h0);
        chk("t6_re_all", 64'(re_o), 64'hF);
        chk("t6_evt_rise", 64'(evt_o), 64'hA);
        repeat (2) step(1, 4'h0, 8'hE4, 0, 4'h0);
        step(1, 4'h0, 8'hE4, 0, 4'h0);
        chk("t6_evt_fall", 64'(evt_o), 64'hC);
        step(1, 4'h0, 8'hE4, 0, 4'h0);
        chk("t6_cnt", 64'(cnt_o), {32'h0, 8'd2, 8'd1, 8'd1, 8'd0});

        // randomized traffic
        rd = '0; rm = 8'hE4; rt = 1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CH; i++) if ($urandom_range(0, 3) == 0) rd[i] = ~rd[i];
            if (k % 50 == 0) rt = $urandom_range(0, 4);
            if (k % 37 == 0) rm = 8'($urandom);
            step(($urandom_range(0, 299) != 0), rd, rm, rt,
                 ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
